// File: rtl/score_disp_pkg.sv
// score_disp_pkg: active-low 7-segment glyphs, glyph lookup and converter FSM states
package score_disp_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/score_display_scanner_if.sv
// score_display_scanner_if: value/load/blink in, segment/anode/status out
interface score_display_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] value;
  logic load;
  logic blink_en;
  logic [6:0] segval;
  logic [NUM_DIGITS-1:0] whichseg;
  logic busy;
  logic overflow;
  modport master (output value, load, blink_en, input segval, whichseg, busy, overflow);
  modport slave (input value, load, blink_en, output segval, whichseg, busy, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter, done pulses in COMMIT
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic switchClk,
  input  logic rst,
  input  logic start,
  input  logic [BIN_W-1:0] bin,
  output logic busy,
  output logic done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
  state_t state, state_nx;
  logic [BW+BIN_W-1:0] sr, adj;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sr[BIN_W+4*i +: 4] >= 4'd5) adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? CONVERT : IDLE;
      CONVERT: state_nx = (cnt == CW'(BIN_W - 1)) ? COMMIT : CONVERT;
      default: state_nx = start ? CONVERT : IDLE;
    endcase
  end
  always_ff @(posedge switchClk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (start && state != CONVERT) begin
        sr <= {{BW{1'b0}}, bin};
        cnt <= '0;
      end else if (state == CONVERT) begin
        sr <= {adj[BW+BIN_W-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == COMMIT;
  assign bcd = sr[BW+BIN_W-1:BIN_W];
endmodule

// File: rtl/score_display_scanner.sv
// score_display_scanner: BCD conversion with pending reload, multiplexed 7-seg scan, blanking, dashes and blink
module score_display_scanner
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W = 14,
  parameter int BLANK_LEAD = 1,
  parameter int BLINK_DIV = 64
) (
  input logic switchClk,
  input logic rst,
  score_display_scanner_if.slave bus
);
  localparam longint OVF_MAX = longint'(10) ** NUM_DIGITS - 1;
  localparam int KW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BCW = $clog2(BLINK_DIV + 1);
  logic [BIN_W-1:0] pend_val, conv_in;
  logic pending, start, conv_busy, done, ovf_cap, phase, z;
  logic [4*NUM_DIGITS-1:0] acc, disp;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [KW-1:0] k;
  logic [BCW-1:0] bcnt;
  logic [6:0] glyph;
  bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .switchClk(switchClk), .rst(rst), .start(start), .bin(conv_in),
    .busy(conv_busy), .done(done), .bcd(acc)
  );
  // a fresh load in IDLE beats a stale pending value; COMMIT chains straight into pending
  assign start = (!conv_busy && (bus.load || pending)) || (done && pending);
  assign conv_in = (!conv_busy && bus.load) ? bus.value : pend_val;
  assign bus.busy = conv_busy;
  always_comb begin
    z = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (disp[4*i +: 4] == 4'd0);
      lead_zero[i] = z;
    end
    glyph = bus.overflow ? SEG_DASH :
            (BLANK_LEAD != 0 && k != '0 && lead_zero[k]) ? SEG_BLANK : seg_glyph(disp[4*k +: 4]);
  end
  always_ff @(posedge switchClk) begin
    if (rst) begin
      pending <= 1'b0;
      pend_val <= '0;
      ovf_cap <= 1'b0;
      disp <= '0;
      bus.overflow <= 1'b0;
      k <= '0;
      bcnt <= '0;
      phase <= 1'b1;
      bus.segval <= SEG_BLANK;
      bus.whichseg <= '1;
    end else begin
      pending <= (bus.load && conv_busy) || (pending && !start);
      if (bus.load && conv_busy) pend_val <= bus.value;
      if (start) ovf_cap <= longint'(conv_in) > OVF_MAX;
      if (done) begin
        disp <= acc;
        bus.overflow <= ovf_cap;
      end
      k <= (k == KW'(NUM_DIGITS - 1)) ? '0 : k + 1'b1;
      if (!bus.blink_en) begin
        bcnt <= '0;
        phase <= 1'b1;
      end else if (k == KW'(NUM_DIGITS - 1)) begin
        bcnt <= (bcnt == BCW'(BLINK_DIV - 1)) ? '0 : bcnt + 1'b1;
        phase <= (bcnt == BCW'(BLINK_DIV - 1)) ? !phase : phase;
      end
      bus.segval <= glyph;
      bus.whichseg <= (bus.blink_en && !phase) ? '1 : ~(NUM_DIGITS'(1) << k);
    end
  end
endmodule

// File: tb/tb_score_display_scanner.sv
// tb_score_display_scanner: table-driven display checks plus pending, reset and blink sequences
module tb_score_display_scanner;
  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0000100, GB = 7'h7F, GD = 7'b1111110;
  localparam int BUSY_CYC = 15;
  typedef struct packed {
    logic [13:0] v;
    logic [3:0][6:0] g;
    logic ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  vec_t vecs [8];
  always #5 clk = ~clk;
  score_display_scanner_if #(.NUM_DIGITS(4), .BIN_W(14)) bus ();
  score_display_scanner #(.NUM_DIGITS(4), .BIN_W(14), .BLANK_LEAD(1), .BLINK_DIV(2)) dut (
    .switchClk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_load(input logic [13:0] v);
    bus.value = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic scan(input string name, input logic [3:0][6:0] g);
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({name, " anode onehot"}, $countones(~bus.whichseg), 1);
      for (int d = 0; d < 4; d++)
        if (!bus.whichseg[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("%s seg%0d", name, d), bus.segval, g[d]);
        end
    end
    chk({name, " digits seen"}, seen, 4'hF);
  endtask
  initial begin
    int n, last, ntrans;
    logic offs [96];
    bus.value = '0;
    bus.load = 1'b0;
    bus.blink_en = 1'b0;
    vecs[0] = '{14'd1234, {G1, G2, G3, G4}, 1'b0};
    vecs[1] = '{14'd7, {GB, GB, GB, G7}, 1'b0};
    vecs[2] = '{14'd0, {GB, GB, GB, G0}, 1'b0};
    vecs[3] = '{14'd100, {GB, G1, G0, G0}, 1'b0};
    vecs[4] = '{14'd9999, {G9, G9, G9, G9}, 1'b0};
    vecs[5] = '{14'd10000, {GD, GD, GD, GD}, 1'b1};
    vecs[6] = '{14'd5, {GB, GB, GB, G5}, 1'b0};
    vecs[7] = '{14'd8080, {G8, G0, G8, G0}, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset segval", bus.segval, 7'h7F);
    chk("reset whichseg", bus.whichseg, 4'hF);
    chk("reset busy", bus.busy, 0);
    chk("reset overflow", bus.overflow, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse_load(vecs[i].v);
      wait_idle(n);
      chk($sformatf("busy cycles v=%0d", vecs[i].v), n, BUSY_CYC);
      chk($sformatf("overflow v=%0d", vecs[i].v), bus.overflow, vecs[i].ovf);
      scan($sformatf("v=%0d", vecs[i].v), vecs[i].g);
    end
    pulse_load(14'd42);
    repeat (3) @(negedge clk);
    pulse_load(14'd99);
    pulse_load(14'd55);
    repeat (10) @(negedge clk);
    chk("chained busy", bus.busy, 1);
    scan("first of chain 42", {GB, GB, G4, G2});
    wait_idle(n);
    chk("chained tail busy", n, 11);
    scan("latest pending 55", {GB, GB, G5, G5});
    pulse_load(14'd1234);
    repeat (2) @(negedge clk);
    pulse_load(14'd77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort segval", bus.segval, 7'h7F);
    chk("abort whichseg", bus.whichseg, 4'hF);
    chk("abort overflow", bus.overflow, 0);
    repeat (20) @(negedge clk);
    chk("abort pending cleared", bus.busy, 0);
    scan("after abort", {GB, GB, GB, G0});
    bus.blink_en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      offs[i] = (bus.whichseg == 4'hF);
    end
    last = 0;
    ntrans = 0;
    for (int i = 1; i < 96; i++)
      if (offs[i] != offs[i-1]) begin
        if (ntrans != 0) chk("blink run length", i - last, 8);
        last = i;
        ntrans++;
      end
    chk("blink transitions", ntrans >= 10, 1);
    n = 0;
    while (bus.whichseg != 4'hF && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("blink off phase reached", bus.whichseg, 4'hF);
    bus.blink_en = 1'b0;
    @(negedge clk);
    chk("blink drop resumes anodes", $countones(~bus.whichseg), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
